alu_issue_stage: RTL and testbench

- Registered issue/retire stage wrapped around the combinational alu_core.
- Accepts high-level opcodes with operands over a valid/ready handshake, decodes each into alu_core controls (S, M, Cin) and keeps an architectural flag register (C, V, N, Z) so ADC/SBC chain across words.
- Results and flags are buffered in a 2-entry output FIFO toward the writeback consumer.

---
 rtl/alu_issue_pkg.sv | 45 ++++
 rtl/alu_core.sv | 48 ++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: opcodes, alu_core S-codes and flag bit positions.
// S-codes act as a per-bit truth table indexed by {a,b} in logic mode.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_NAND = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_NOTA = 4'hB;
    localparam logic [3:0] OP_MOVA = 4'hC;
    localparam logic [3:0] OP_MOVB = 4'hD;
    localparam logic [3:0] OP_CLRC = 4'hE;
    localparam logic [3:0] OP_SETC = 4'hF;

    localparam logic [3:0] S_ADD  = 4'b1001;
    localparam logic [3:0] S_SUB  = 4'b0110;
    localparam logic [3:0] S_AND  = 4'b1000;
    localparam logic [3:0] S_OR   = 4'b1110;
    localparam logic [3:0] S_XOR  = 4'b0110;
    localparam logic [3:0] S_NOR  = 4'b0001;
    localparam logic [3:0] S_NAND = 4'b0111;
    localparam logic [3:0] S_XNOR = 4'b1001;
    localparam logic [3:0] S_NOTA = 4'b0011;
    localparam logic [3:0] S_MOVA = 4'b1100;
    localparam logic [3:0] S_MOVB = 4'b1010;
    localparam logic [3:0] S_ZERO = 4'b0000;
    localparam logic [3:0] S_ONES = 4'b1111;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    function automatic logic is_arith(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: 4-bit S truth-table logic unit plus adder with true carry-in.
// In arithmetic mode S[3:2] selects B or ~B as the second adder operand.
module alu_core #(
    parameter int n = 32
) (
    input  logic [3:0]   s,
    input  logic         m,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] dout,
    output logic         c,
    output logic         v,
    output logic         neg,
    output logic         zero
);

    logic [n-1:0] lut_s;
    logic [n-1:0] b_eff_s;
    logic [n:0]   sum_s;

    // Per-bit truth-table lookup, operand conditioning and the adder
    always_comb begin
        lut_s   = {n{1'b0}};
        b_eff_s = {n{1'b0}};
        for (int i = 0; i < n; i++) begin
            lut_s[i]   = s[{a[i], b[i]}];
            b_eff_s[i] = s[{1'b1, b[i]}];
        end
        sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{n{1'b0}}, cin};
    end

    // Mode select and flag generation
    always_comb begin
        if (m) begin
            dout = sum_s[n-1:0];
            c    = sum_s[n];
            v    = (a[n-1] == b_eff_s[n-1]) && (sum_s[n-1] != a[n-1]);
        end else begin
            dout = lut_s;
            c    = 1'b0;
            v    = 1'b0;
        end
        neg  = dout[n-1];
        zero = (dout == {n{1'b0}});
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around alu_core: opcode decode, architectural CVNZ flags and a
// 2-entry output FIFO. in_ready depends only on the registered occupancy.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [n-1:0] in_a,
    input  logic [n-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [3:0]   out_flags,
    output logic         out_wr
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [3:0]   flags_r;
    logic [3:0]   flags_next_s;
    logic [3:0]   s_code_s;
    logic         m_sel_s;
    logic         cin_s;
    logic         wr_s;
    logic [n-1:0] alu_do_s;
    logic         alu_c_s;
    logic         alu_v_s;
    logic         alu_n_s;
    logic         alu_z_s;
    logic         push_s;
    logic         pop_s;

    logic [n-1:0] data_mem_r  [2];
    logic [3:0]   flags_mem_r [2];
    logic         wr_mem_r    [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;

    alu_core #(.n(n)) u_alu_core (
        .s    (s_code_s),
        .m    (m_sel_s),
        .cin  (cin_s),
        .a    (in_a),
        .b    (in_b),
        .dout (alu_do_s),
        .c    (alu_c_s),
        .v    (alu_v_s),
        .neg  (alu_n_s),
        .zero (alu_z_s)
    );

    assign in_ready  = (count_r < FULL);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = data_mem_r[rd_ptr_r];
    assign out_flags = flags_mem_r[rd_ptr_r];
    assign out_wr    = wr_mem_r[rd_ptr_r];
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Opcode to alu_core controls; ADC/SBC carry comes from the already-updated flag register
    always_comb begin
        s_code_s = S_ADD;
        m_sel_s  = 1'b0;
        cin_s    = 1'b0;
        wr_s     = 1'b1;
        case (in_op)
            OP_ADD:  begin s_code_s = S_ADD;  m_sel_s = 1'b1; cin_s = 1'b0; end
            OP_ADC:  begin s_code_s = S_ADD;  m_sel_s = 1'b1; cin_s = flags_r[FLG_C]; end
            OP_SUB:  begin s_code_s = S_SUB;  m_sel_s = 1'b1; cin_s = 1'b1; end
            OP_SBC:  begin s_code_s = S_SUB;  m_sel_s = 1'b1; cin_s = flags_r[FLG_C]; end
            OP_CMP:  begin s_code_s = S_SUB;  m_sel_s = 1'b1; cin_s = 1'b1; wr_s = 1'b0; end
            OP_AND:  s_code_s = S_AND;
            OP_OR:   s_code_s = S_OR;
            OP_XOR:  s_code_s = S_XOR;
            OP_NOR:  s_code_s = S_NOR;
            OP_NAND: s_code_s = S_NAND;
            OP_XNOR: s_code_s = S_XNOR;
            OP_NOTA: s_code_s = S_NOTA;
            OP_MOVA: s_code_s = S_MOVA;
            OP_MOVB: s_code_s = S_MOVB;
            OP_CLRC: begin s_code_s = S_ZERO; wr_s = 1'b0; end
            OP_SETC: begin s_code_s = S_ONES; wr_s = 1'b0; end
            default: begin s_code_s = S_ZERO; wr_s = 1'b0; end
        endcase
    end

    // Flag register next value for the op being presented
    always_comb begin
        flags_next_s = flags_r;
        if (is_arith(in_op)) begin
            flags_next_s = {alu_c_s, alu_v_s, alu_n_s, alu_z_s};
        end else if (in_op == OP_CLRC) begin
            flags_next_s[FLG_C] = 1'b0;
        end else if (in_op == OP_SETC) begin
            flags_next_s[FLG_C] = 1'b1;
        end else begin
            flags_next_s[FLG_N] = alu_n_s;
            flags_next_s[FLG_Z] = alu_z_s;
        end
    end

    // Architectural flags update on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'b0000;
        end else if (push_s) begin
            flags_r <= flags_next_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_mem_r[i]  <= {n{1'b0}};
                flags_mem_r[i] <= 4'b0000;
                wr_mem_r[i]    <= 1'b0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r]  <= alu_do_s;
                flags_mem_r[wr_ptr_r] <= flags_next_s;
                wr_mem_r[wr_ptr_r]    <= wr_s;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + 2'd1;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - 2'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model compared every cycle,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  f;
        logic        w;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'h0;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic        out_wr;

    int   checks = 0;
    int   failures = 0;
    ent_t mq[$];
    logic [3:0] mflags = 4'b0000;
    logic last_acc = 1'b0;

    alu_issue_stage #(.n(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_wr    (out_wr)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one op given the current flags
    function automatic ent_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] f);
        ent_t e;
        logic [32:0] s;
        e.f = f;
        e.w = 1'b1;
        e.d = 32'h0;
        s = 33'h0;
        case (op)
            4'h0, 4'h1: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 4'h1) ? 33'(f[3]) : 33'h0);
                e.d = s[31:0];
                e.f[3] = s[32];
                e.f[2] = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'h2, 4'h3, 4'h4: begin
                s = {1'b0, a} + {1'b0, ~b} + ((op == 4'h3) ? 33'(f[3]) : 33'h1);
                e.d = s[31:0];
                e.f[3] = s[32];
                e.f[2] = (a[31] != b[31]) && (s[31] != a[31]);
                if (op == 4'h4) e.w = 1'b0;
            end
            4'h5: e.d = a & b;
            4'h6: e.d = a | b;
            4'h7: e.d = a ^ b;
            4'h8: e.d = ~(a | b);
            4'h9: e.d = ~(a & b);
            4'hA: e.d = ~(a ^ b);
            4'hB: e.d = ~a;
            4'hC: e.d = a;
            4'hD: e.d = b;
            4'hE: begin e.d = 32'h0; e.f[3] = 1'b0; e.w = 1'b0; end
            default: begin e.d = 32'hFFFF_FFFF; e.f[3] = 1'b1; e.w = 1'b0; end
        endcase
        if (op <= 4'hD) begin
            e.f[1] = e.d[31];
            e.f[0] = (e.d == 32'h0);
        end
        return e;
    endfunction

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later
    task automatic tick();
        ent_t h;
        ent_t e;
        logic acc;
        logic pop;
        @(negedge clk);
        checks++;
        if (in_ready !== (mq.size() < 2)) begin
            failures++;
            $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, (mq.size() < 2));
        end
        checks++;
        if (mq.size() == 0) begin
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL out_valid_idle t=%0t got=%b want=0", $time, out_valid);
            end
        end else begin
            h = mq[0];
            if (out_valid !== 1'b1 || out_data !== h.d || out_flags !== h.f || out_wr !== h.w) begin
                failures++;
                $display("FAIL head t=%0t got v=%b d=%h f=%b w=%b want v=1 d=%h f=%b w=%b",
                         $time, out_valid, out_data, out_flags, out_wr, h.d, h.f, h.w);
            end
        end
        @(posedge clk);
        acc = rst_n && in_valid && (mq.size() < 2);
        pop = rst_n && out_ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            e = model(in_op, in_a, in_b, mflags);
            mflags = e.f;
            mq.push_back(e);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        checks++;
        if (!last_acc) begin
            failures++;
            $display("FAIL send_timeout op=%h got=not_accepted want=accepted", op);
        end
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic [3:0] f, input logic w);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_flags !== f || out_wr !== w) begin
            failures++;
            $display("FAIL %s got v=%b d=%h f=%b w=%b want v=1 d=%h f=%b w=%b",
                     name, out_valid, out_data, out_flags, out_wr, d, f, w);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3;
        chk_bit("reset_out_valid", out_valid, 1'b0);
        checks++;
        if (out_data !== 32'h0 || out_flags !== 4'h0 || out_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got d=%h f=%b w=%b want d=0 f=0000 w=0", out_data, out_flags, out_wr);
        end
        #9 rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(4'h0, 32'h0101_0000, 32'h1010_0101); lit("add", 32'h1111_0101, 4'b0000, 1'b1);
        send(4'h2, 32'h8000_0000, 32'h0000_0001); lit("sub_ovf", 32'h7FFF_FFFF, 4'b1100, 1'b1);
        send(4'h2, 32'h0000_FFFF, 32'h0001_0000); lit("sub_borrow", 32'hFFFF_FFFF, 4'b0010, 1'b1);
        send(4'h0, 32'hFFFF_FFFF, 32'h0000_0001); lit("add_carry", 32'h0000_0000, 4'b1001, 1'b1);
        send(4'h1, 32'h0000_0000, 32'h0000_0000); lit("adc_chain", 32'h0000_0001, 4'b0000, 1'b1);
        send(4'h4, 32'd5, 32'd5);                 lit("cmp", 32'h0000_0000, 4'b1001, 1'b0);
        send(4'h5, 32'hF0F0_F0F0, 32'h0F0F_0F0F); lit("and_keep_c", 32'h0000_0000, 4'b1001, 1'b1);
        send(4'hE, 32'h1234_5678, 32'h0);         lit("clrc", 32'h0000_0000, 4'b0001, 1'b0);
        send(4'h3, 32'd10, 32'd3);                lit("sbc", 32'h0000_0006, 4'b1000, 1'b1);
        tick();

        out_ready = 1'b0;
        send(4'h0, 32'd1, 32'd2);
        send(4'h0, 32'd3, 32'd4);
        in_op = 4'h0; in_a = 32'd5; in_b = 32'd6; in_valid = 1'b1;
        tick();
        chk_bit("full_in_ready", in_ready, 1'b0);
        tick();
        chk_bit("full_held", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_bit("ready_after_pop", in_ready, 1'b1);
        lit("bp_second", 32'd7, 4'b0000, 1'b1);
        tick();
        in_valid = 1'b0;
        lit("bp_third", 32'd11, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        out_ready = 1'b0;
        send(4'h0, 32'hFFFF_FFFF, 32'h1);
        send(4'h0, 32'h1, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_rst_valid", out_valid, 1'b0);
        checks++;
        if (out_flags !== 4'h0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL async_rst_outputs got d=%h f=%b want d=0 f=0000", out_data, out_flags);
        end
        mq.delete();
        mflags = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        chk_bit("post_rst_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send(4'h1, 32'd1, 32'd1); lit("post_rst_adc", 32'd2, 4'b0000, 1'b1);
        tick();

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op = 4'($urandom_range(0, 15));
            in_a = rand_operand();
            in_b = rand_operand();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
